// File: rtl/pwm_timebase_if.sv
// Register-side bundle for pwm_timebase: control/config inputs and time-base status outputs.
interface pwm_timebase_if #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
);
  logic             en;
  logic             count_reset;
  logic [1:0]       mode;
  logic             one_shot;
  logic [CNT_W-1:0] period;
  logic [PSC_W-1:0] prescale;
  logic [CNT_W-1:0] count_val;
  logic             dir;
  logic             tick;
  logic             ovf;
  logic             unf;
  logic             running;

  modport master (
    output en, count_reset, mode, one_shot, period, prescale,
    input  count_val, dir, tick, ovf, unf, running
  );

  modport slave (
    input  en, count_reset, mode, one_shot, period, prescale,
    output count_val, dir, tick, ovf, unf, running
  );
endinterface

// File: rtl/pwm_timebase.sv
// PWM time base: up / down / center-aligned counter with prescaler, one-shot and event pulses.
// Define PWM_TIMEBASE_SHADOW_EN to latch period/prescale/mode only at reset, restart and terminal events.
module pwm_timebase #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_timebase_if.slave  bus
);
  localparam logic [1:0]       MODE_DN = 2'b01;
  localparam logic [1:0]       MODE_UD = 2'b10;
  localparam logic [CNT_W-1:0] C_ONE   = 1;
  localparam logic [PSC_W-1:0] P_ONE   = 1;

  logic [CNT_W-1:0] cnt_q, cnt_n, per_act;
  logic [PSC_W-1:0] psc_q, psc_act;
  logic [1:0]       mode_act;
  logic             dir_q, dir_n, tick_q, ovf_q, unf_q, run_q;
  logic             ovf_n, unf_n, term_n, step;

  assign step = bus.en && run_q && (psc_q == psc_act);

`ifdef PWM_TIMEBASE_SHADOW_EN
  logic [CNT_W-1:0] per_sh;
  logic [PSC_W-1:0] psc_sh;
  logic [1:0]       mode_sh;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.count_reset || (step && term_n)) begin
      per_sh  <= bus.period;
      psc_sh  <= bus.prescale;
      mode_sh <= bus.mode;
    end
  end

  assign per_act  = per_sh;
  assign psc_act  = psc_sh;
  assign mode_act = mode_sh;
`else
  assign per_act  = bus.period;
  assign psc_act  = bus.prescale;
  assign mode_act = bus.mode;
`endif

  // Next count/direction for one step; only committed when the prescaler rolls over.
  always_comb begin
    cnt_n = cnt_q;
    dir_n = dir_q;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    case (mode_act)
      MODE_DN: begin
        dir_n = 1'b0;
        if (cnt_q == '0) begin
          cnt_n = per_act;
          unf_n = 1'b1;
        end else begin
          cnt_n = cnt_q - C_ONE;
        end
      end
      MODE_UD: begin
        if (dir_q) begin
          if (cnt_q >= per_act) begin
            dir_n = 1'b0;
            cnt_n = (per_act == '0) ? '0 : per_act - C_ONE;
            ovf_n = 1'b1;
          end else begin
            cnt_n = cnt_q + C_ONE;
          end
        end else begin
          if (cnt_q == '0) begin
            dir_n = 1'b1;
            cnt_n = (per_act == '0) ? '0 : C_ONE;
            unf_n = 1'b1;
          end else begin
            cnt_n = cnt_q - C_ONE;
          end
        end
      end
      default: begin
        dir_n = 1'b1;
        if (cnt_q >= per_act) begin
          cnt_n = '0;
          ovf_n = 1'b1;
        end else begin
          cnt_n = cnt_q + C_ONE;
        end
      end
    endcase
    term_n = (mode_act == MODE_DN || mode_act == MODE_UD) ? unf_n : ovf_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      psc_q  <= '0;
      dir_q  <= 1'b1;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      run_q  <= 1'b1;
    end else if (bus.count_reset) begin
      // Restart follows the live inputs, which are also what the shadows capture here.
      psc_q  <= '0;
      run_q  <= 1'b1;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      if (bus.mode == MODE_DN) begin
        cnt_q <= bus.period;
        dir_q <= 1'b0;
      end else begin
        cnt_q <= '0;
        dir_q <= 1'b1;
      end
    end else if (step) begin
      psc_q  <= '0;
      cnt_q  <= cnt_n;
      dir_q  <= dir_n;
      tick_q <= 1'b1;
      ovf_q  <= ovf_n;
      unf_q  <= unf_n;
      if (term_n && bus.one_shot) run_q <= 1'b0;
    end else begin
      if (bus.en && run_q) psc_q <= psc_q + P_ONE;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end
  end

  assign bus.count_val = cnt_q;
  assign bus.dir       = dir_q;
  assign bus.tick      = tick_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.running   = run_q;
endmodule
